// File: rtl/i2c_codec_responder.sv
// I2C write-only target modelling the WM8731 control port: oversampled SCL/SDA,
// START/STOP decode, address match with ACK, and 7-bit-address/9-bit-data register writes.
module i2c_codec_responder #(
  parameter logic [6:0] DEV_ADDR  = 7'h1A,
  parameter int         NUM_REGS  = 10,
  parameter logic [6:0] RESET_REG = 7'h0F
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  input  logic [6:0] i_rd_addr,
  output logic [8:0] o_rd_data,
  output logic       o_reg_wr,
  output logic [6:0] o_reg_addr,
  output logic [8:0] o_reg_data,
  output logic [7:0] o_wr_cnt,
  output logic       o_busy,
  output logic [2:0] o_state
);
  localparam int         AW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [6:0] NUM_REGS_A = 7'(NUM_REGS);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DEV    = 3'd1,
    S_ACK    = 3'd2,
    S_B1     = 3'd3,
    S_B2     = 3'd4,
    S_IGNORE = 3'd5
  } state_t;

  state_t     state, state_nxt, ret, ret_nxt;
  logic       scl_p0, scl_p1, scl_p2;
  logic       sda_p0, sda_p1, sda_p2;
  logic       scl_rise, scl_fall, start_det, stop_det;
  logic [3:0] bit_cnt, bit_cnt_nxt;
  logic [7:0] shreg, shreg_nxt;
  logic [6:0] wr_addr, wr_addr_nxt;
  logic       d8, d8_nxt;
  logic       oe_nxt, commit;
  logic [8:0] regs [NUM_REGS];

  // Synchroniser stages p0/p1 plus history p2; reset to the bus-idle level
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      scl_p0 <= 1'b1; scl_p1 <= 1'b1; scl_p2 <= 1'b1;
      sda_p0 <= 1'b1; sda_p1 <= 1'b1; sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= i_scl; scl_p1 <= scl_p0; scl_p2 <= scl_p1;
      sda_p0 <= i_sda; sda_p1 <= sda_p0; sda_p2 <= sda_p1;
    end
  end

  // SDA edges only count as START/STOP when SCL was stable high across the sample
  assign scl_rise  = scl_p1 & ~scl_p2;
  assign scl_fall  = ~scl_p1 & scl_p2;
  assign start_det = scl_p1 & scl_p2 & sda_p2 & ~sda_p1;
  assign stop_det  = scl_p1 & scl_p2 & ~sda_p2 & sda_p1;

  always_comb begin
    state_nxt   = state;
    ret_nxt     = ret;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    wr_addr_nxt = wr_addr;
    d8_nxt      = d8;
    oe_nxt      = o_sda_oe;
    commit      = 1'b0;
    if (start_det) begin
      state_nxt   = S_DEV;
      bit_cnt_nxt = '0;
      oe_nxt      = 1'b0;
    end else if (stop_det) begin
      state_nxt   = S_IDLE;
      bit_cnt_nxt = '0;
      oe_nxt      = 1'b0;
    end else begin
      case (state)
        S_DEV, S_B1, S_B2: begin
          if (scl_rise && bit_cnt != 4'd8) begin
            shreg_nxt   = {shreg[6:0], sda_p1};
            bit_cnt_nxt = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_nxt = '0;
            state_nxt   = S_ACK;
            oe_nxt      = 1'b1;
            if (state == S_DEV) begin
              ret_nxt = S_B1;
              if (shreg[7:1] != DEV_ADDR || shreg[0]) begin
                state_nxt = S_IGNORE;
                oe_nxt    = 1'b0;
              end
            end else if (state == S_B1) begin
              wr_addr_nxt = shreg[7:1];
              d8_nxt      = shreg[0];
              ret_nxt     = S_B2;
            end else begin
              commit  = 1'b1;
              ret_nxt = S_IGNORE;
            end
          end
        end
        S_ACK: begin
          if (scl_fall) begin
            oe_nxt    = 1'b0;
            state_nxt = ret;
          end
        end
        default: ;
      endcase
    end
  end

  // Control state and the commit stage into the register file
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= S_IDLE;
      ret        <= S_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      wr_addr    <= '0;
      d8         <= 1'b0;
      o_sda_oe   <= 1'b0;
      o_reg_wr   <= 1'b0;
      o_reg_addr <= '0;
      o_reg_data <= '0;
      o_wr_cnt   <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      state    <= state_nxt;
      ret      <= ret_nxt;
      bit_cnt  <= bit_cnt_nxt;
      shreg    <= shreg_nxt;
      wr_addr  <= wr_addr_nxt;
      d8       <= d8_nxt;
      o_sda_oe <= oe_nxt;
      o_reg_wr <= commit;
      if (commit) begin
        o_reg_addr <= wr_addr;
        o_reg_data <= {d8, shreg};
        o_wr_cnt   <= o_wr_cnt + 8'd1;
        if (wr_addr == RESET_REG) begin
          for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else if (wr_addr < NUM_REGS_A) begin
          regs[wr_addr[AW-1:0]] <= {d8, shreg};
        end
      end
    end
  end

  always_comb begin
    o_rd_data = '0;
    if (i_rd_addr < NUM_REGS_A) o_rd_data = regs[i_rd_addr[AW-1:0]];
  end

  assign o_busy  = (state != S_IDLE);
  assign o_state = state;
endmodule

// File: tb/tb_i2c_codec_responder.sv
// Bench for i2c_codec_responder: bit-banged I2C manager on a wired-AND SDA bus,
// checked against a transaction-level register-file model.
module tb_i2c_codec_responder;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_bus;
  logic       sda_oe;
  logic [6:0] rd_addr = '0;
  logic [8:0] rd_data;
  logic       reg_wr;
  logic [6:0] reg_addr;
  logic [8:0] reg_data;
  logic [7:0] wr_cnt;
  logic       busy;
  logic [2:0] state;

  assign sda_bus = sda_m & ~sda_oe;

  i2c_codec_responder dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_scl(scl_m), .i_sda(sda_bus),
    .o_sda_oe(sda_oe), .i_rd_addr(rd_addr), .o_rd_data(rd_data),
    .o_reg_wr(reg_wr), .o_reg_addr(reg_addr), .o_reg_data(reg_data),
    .o_wr_cnt(wr_cnt), .o_busy(busy), .o_state(state)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_miss = 0;

  // Bus monitors
  int   wr_pulses = 0, long_pulses = 0, hi_viol = 0, oe_cycles = 0;
  logic prev_oe = 1'b0, prev_scl = 1'b1, prev_wr = 1'b0, prev_rst = 1'b0;
  always @(negedge clk) begin
    if (sda_oe) oe_cycles <= oe_cycles + 1;
    if (reg_wr) wr_pulses <= wr_pulses + 1;
    if (reg_wr && prev_wr) long_pulses <= long_pulses + 1;
    if (rst_n && prev_rst && sda_oe !== prev_oe && scl_m && prev_scl) hi_viol <= hi_viol + 1;
    prev_oe <= sda_oe; prev_scl <= scl_m; prev_wr <= reg_wr; prev_rst <= rst_n;
  end

  // Reference model: register image indexed by full 7-bit address
  logic [8:0] m_regs [128];
  int         m_cnt;

  task automatic m_reset();
    for (int i = 0; i < 128; i++) m_regs[i] = '0;
    m_cnt = 0;
  endtask

  task automatic m_write(input logic [7:0] b1, input logic [7:0] b2);
    logic [6:0] ad;
    ad = b1[7:1];
    m_cnt = (m_cnt + 1) % 256;
    if (ad == 7'h0F) begin
      for (int i = 0; i < 128; i++) m_regs[i] = '0;
    end else if (ad < 7'd10) begin
      m_regs[ad] = {b1[0], b2};
    end
  endtask

  // Bus manager
  logic [7:0] fb [8];
  logic       ack [8];

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b, output logic seen);
    sda_m = b;   cyc(2);
    scl_m = 1'b1; cyc(2);
    seen = sda_bus; cyc(2);
    scl_m = 1'b0; cyc(2);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic a);
    logic s;
    for (int i = 7; i >= 0; i--) send_bit(b[i], s);
    send_bit(1'b1, s);
    a = ~s;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; cyc(2);
    scl_m = 1'b1; cyc(4);
    sda_m = 1'b0; cyc(4);
    scl_m = 1'b0; cyc(2);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; cyc(2);
    scl_m = 1'b1; cyc(4);
    sda_m = 1'b1; cyc(4);
  endtask

  task automatic run_frame(input int len, input logic do_stop);
    logic a;
    i2c_start();
    for (int i = 0; i < len; i++) begin
      send_byte(fb[i], a);
      ack[i] = a;
    end
    if (do_stop) i2c_stop();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; scl_m = 1'b1; sda_m = 1'b1;
    cyc(3);
    n_vec++;
    if ({sda_oe, reg_wr, reg_addr, reg_data, wr_cnt, busy, state} !== '0) begin
      n_miss++;
      $display("FAIL reset_outputs: got oe=%b wr=%b addr=%h data=%h cnt=%h busy=%b st=%0d, need all 0",
               sda_oe, reg_wr, reg_addr, reg_data, wr_cnt, busy, state);
    end
    for (int a = 0; a < 12; a++) begin
      rd_addr = 7'(a); #1;
      n_vec++;
      if (rd_data !== 9'h000) begin
        n_miss++; $display("FAIL reset_rd[%0d]: got %h need 000", a, rd_data);
      end
    end
    rst_n = 1'b1; cyc(2);
    m_reset();
  endtask

  task automatic test_single_write();
    int p0;
    p0 = wr_pulses;
    fb[0] = 8'h34; fb[1] = 8'h08; fb[2] = 8'h15;
    run_frame(3, 1'b1);
    m_write(fb[1], fb[2]);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (ack[i] !== 1'b1) begin n_miss++; $display("FAIL single_ack[%0d]: got %b need 1", i, ack[i]); end
    end
    n_vec++;
    if (wr_pulses - p0 !== 1) begin n_miss++; $display("FAIL single_pulses: got %0d need 1", wr_pulses - p0); end
    n_vec++;
    if (reg_addr !== 7'd4 || reg_data !== 9'h015) begin
      n_miss++; $display("FAIL single_last: got addr=%h data=%h need 04/015", reg_addr, reg_data);
    end
    rd_addr = 7'd4; #1;
    n_vec++;
    if (rd_data !== 9'h015) begin n_miss++; $display("FAIL single_rd4: got %h need 015", rd_data); end
    n_vec++;
    if (wr_cnt !== 8'd1) begin n_miss++; $display("FAIL single_cnt: got %0d need 1", wr_cnt); end
    n_vec++;
    if (busy !== 1'b0 || state !== 3'd0) begin
      n_miss++; $display("FAIL single_idle: got busy=%b st=%0d need 0/0", busy, state);
    end
  endtask

  task automatic test_reset_reg();
    fb[0] = 8'h34; fb[1] = 8'h0F; fb[2] = 8'hFF;
    run_frame(3, 1'b1);
    m_write(fb[1], fb[2]);
    rd_addr = 7'd7; #1;
    n_vec++;
    if (rd_data !== 9'h1FF) begin n_miss++; $display("FAIL resetreg_rd7: got %h need 1ff", rd_data); end
    fb[1] = 8'h1E; fb[2] = 8'h00;
    run_frame(3, 1'b1);
    m_write(fb[1], fb[2]);
    for (int a = 0; a < 10; a++) begin
      rd_addr = 7'(a); #1;
      n_vec++;
      if (rd_data !== m_regs[a]) begin
        n_miss++; $display("FAIL resetreg_clear[%0d]: got %h need %h", a, rd_data, m_regs[a]);
      end
    end
    n_vec++;
    if (wr_cnt !== 8'(m_cnt)) begin n_miss++; $display("FAIL resetreg_cnt: got %0d need %0d", wr_cnt, m_cnt); end
  endtask

  task automatic test_no_match();
    int p0, o0;
    logic [7:0] hdr [2];
    hdr[0] = 8'h36; hdr[1] = 8'h35;
    for (int f = 0; f < 2; f++) begin
      p0 = wr_pulses; o0 = oe_cycles;
      fb[0] = hdr[f]; fb[1] = 8'($urandom); fb[2] = 8'($urandom);
      run_frame(3, 1'b1);
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (ack[i] !== 1'b0) begin n_miss++; $display("FAIL nomatch_ack[%h][%0d]: got %b need 0", hdr[f], i, ack[i]); end
      end
      n_vec++;
      if (oe_cycles != o0 || wr_pulses != p0) begin
        n_miss++; $display("FAIL nomatch_quiet[%h]: got oe_cycles=%0d pulses=%0d need 0/0", hdr[f], oe_cycles - o0, wr_pulses - p0);
      end
      n_vec++;
      if (state !== 3'd0) begin n_miss++; $display("FAIL nomatch_state[%h]: got %0d need 0", hdr[f], state); end
    end
  endtask

  task automatic test_repeated_start();
    int p0;
    fb[0] = 8'h34; fb[1] = 8'h08; fb[2] = 8'hAB;
    run_frame(3, 1'b1);
    m_write(fb[1], fb[2]);
    p0 = wr_pulses;
    fb[1] = 8'h08;
    run_frame(2, 1'b0);
    fb[1] = 8'h0A; fb[2] = 8'h01;
    run_frame(3, 1'b1);
    m_write(fb[1], fb[2]);
    n_vec++;
    if (wr_pulses - p0 !== 1) begin n_miss++; $display("FAIL rstart_pulses: got %0d need 1", wr_pulses - p0); end
    for (int a = 4; a < 6; a++) begin
      rd_addr = 7'(a); #1;
      n_vec++;
      if (rd_data !== m_regs[a]) begin n_miss++; $display("FAIL rstart_rd[%0d]: got %h need %h", a, rd_data, m_regs[a]); end
    end
  endtask

  task automatic test_abort();
    int p0;
    logic a, s;
    p0 = wr_pulses;
    i2c_start();
    send_byte(8'h34, a);
    send_byte(8'h10, a);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom), s);
    n_vec++;
    if (busy !== 1'b1) begin n_miss++; $display("FAIL abort_busy_before: got %b need 1", busy); end
    sda_m = 1'b0; cyc(2);
    scl_m = 1'b1; cyc(4);
    sda_m = 1'b1; cyc(3);
    n_vec++;
    if (busy !== 1'b0 || state !== 3'd0) begin
      n_miss++; $display("FAIL abort_idle: got busy=%b st=%0d need 0/0", busy, state);
    end
    cyc(2);
    n_vec++;
    if (wr_pulses != p0 || wr_cnt !== 8'(m_cnt)) begin
      n_miss++; $display("FAIL abort_nowrite: got pulses=%0d cnt=%0d need 0/%0d", wr_pulses - p0, wr_cnt, m_cnt);
    end
    rd_addr = 7'd8; #1;
    n_vec++;
    if (rd_data !== m_regs[8]) begin n_miss++; $display("FAIL abort_rd8: got %h need %h", rd_data, m_regs[8]); end
  endtask

  task automatic test_mid_reset();
    logic s;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(fb[0][i], s);
    sda_m = 1'b1; cyc(2);
    n_vec++;
    if (sda_oe !== 1'b1) begin n_miss++; $display("FAIL midrst_ack_driven: got %b need 1", sda_oe); end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if (sda_oe !== 1'b0) begin n_miss++; $display("FAIL midrst_release: got %b need 0", sda_oe); end
    scl_m = 1'b1; sda_m = 1'b1;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);
    m_reset();
    n_vec++;
    if (wr_cnt !== 8'd0 || state !== 3'd0) begin
      n_miss++; $display("FAIL midrst_state: got cnt=%0d st=%0d need 0/0", wr_cnt, state);
    end
  endtask

  task automatic test_back_to_back();
    int p0, l0;
    logic [8:0] d;
    p0 = wr_pulses; l0 = long_pulses;
    for (int a = 0; a < 10; a++) begin
      d = 9'($urandom);
      fb[0] = 8'h34; fb[1] = {7'(a), d[8]}; fb[2] = d[7:0]; fb[3] = 8'($urandom);
      run_frame(4, 1'b1);
      m_write(fb[1], fb[2]);
      n_vec++;
      if ({ack[0], ack[1], ack[2], ack[3]} !== 4'b1110) begin
        n_miss++; $display("FAIL b2b_acks[%0d]: got %b%b%b%b need 1110", a, ack[0], ack[1], ack[2], ack[3]);
      end
    end
    n_vec++;
    if (wr_pulses - p0 !== 10 || long_pulses != l0) begin
      n_miss++; $display("FAIL b2b_pulses: got %0d (long %0d) need 10 (0)", wr_pulses - p0, long_pulses - l0);
    end
    for (int a = 0; a < 12; a++) begin
      rd_addr = 7'(a); #1;
      n_vec++;
      if (rd_data !== m_regs[a]) begin n_miss++; $display("FAIL b2b_rd[%0d]: got %h need %h", a, rd_data, m_regs[a]); end
    end
    n_vec++;
    if (wr_cnt !== 8'(m_cnt)) begin n_miss++; $display("FAIL b2b_cnt: got %0d need %0d", wr_cnt, m_cnt); end
  endtask

  task automatic test_random();
    int p0, len, r;
    logic [6:0] ad;
    logic [8:0] d;
    logic exp_ack, does_wr;
    for (int f = 0; f < 30; f++) begin
      r = $urandom_range(0, 16);
      ad = (r == 16) ? 7'h7F : 7'(r);
      d = 9'($urandom);
      fb[0] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h34;
      fb[1] = {ad, d[8]}; fb[2] = d[7:0]; fb[3] = 8'($urandom);
      len = $urandom_range(1, 4);
      p0 = wr_pulses;
      run_frame(len, 1'b1);
      does_wr = (fb[0] == 8'h34) && (len >= 3);
      if (does_wr) m_write(fb[1], fb[2]);
      for (int i = 0; i < len; i++) begin
        exp_ack = (fb[0] == 8'h34) && (i < 3);
        n_vec++;
        if (ack[i] !== exp_ack) begin
          n_miss++; $display("FAIL rand_ack[f%0d b%0d hdr %h]: got %b need %b", f, i, fb[0], ack[i], exp_ack);
        end
      end
      n_vec++;
      if (wr_pulses - p0 !== int'(does_wr) || wr_cnt !== 8'(m_cnt)) begin
        n_miss++; $display("FAIL rand_commit[f%0d]: got pulses=%0d cnt=%0d need %0d/%0d", f, wr_pulses - p0, wr_cnt, does_wr, m_cnt);
      end
      if (does_wr) begin
        n_vec++;
        if (reg_addr !== fb[1][7:1] || reg_data !== {fb[1][0], fb[2]}) begin
          n_miss++; $display("FAIL rand_last[f%0d]: got %h/%h need %h/%h", f, reg_addr, reg_data, fb[1][7:1], {fb[1][0], fb[2]});
        end
      end
    end
    for (int a = 0; a < 17; a++) begin
      rd_addr = (a == 16) ? 7'h7F : 7'(a); #1;
      n_vec++;
      if (rd_data !== m_regs[rd_addr]) begin
        n_miss++; $display("FAIL rand_rd[%0d]: got %h need %h", rd_addr, rd_data, m_regs[rd_addr]);
      end
    end
    n_vec++;
    if (hi_viol != 0) begin n_miss++; $display("FAIL oe_while_scl_high: got %0d changes need 0", hi_viol); end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_write();
    test_reset_reg();
    test_no_match();
    test_repeated_start();
    test_abort();
    fb[0] = 8'h34;
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule

// File: doc/i2c_codec_responder.md
Name: i2c_codec_responder

Overview:
I2C target (responder) modelling the WM8731 codec control port, i.e. the far end of the write-only 3-byte transactions our I2C manager issues during S_INIT. It oversamples SCL/SDA on a fast system clock, decodes START/STOP, matches the device address, ACKs, and commits 7-bit-address/9-bit-data register writes into a small register file. It is used in the top-level bench and as an on-FPGA loopback checker for codec initialisation.

Parameters:
DEV_ADDR, 7'h1A, 7-bit device address answered (write byte 0x34).
NUM_REGS, 10, implemented registers, addresses 0..NUM_REGS-1.
RESET_REG, 7'h0F, writing any data here clears all registers to 0.

Ports:
i_clk  in  1  system clock, at least 8x SCL frequency.
i_rst_n  in  1  asynchronous active-low reset.
i_scl  in  1  I2C clock from bus, asynchronous.
i_sda  in  1  I2C data sampled from bus, asynchronous.
o_sda_oe  out  1  1 = pull SDA low (open-drain), 0 = release.
i_rd_addr  in  7  register file read address.
o_rd_data  out  9  combinational read of reg[i_rd_addr]; 0 if address out of range.
o_reg_wr  out  1  one-cycle pulse per committed write.
o_reg_addr  out  7  address of last committed write.
o_reg_data  out  9  data of last committed write.
o_wr_cnt  out  8  committed-write counter, wraps 255->0.
o_busy  out  1  high from START until STOP or abort.
o_state  out  3  FSM state encoding, for debug display.

Behaviour:
- Reset (async, i_rst_n=0): all outputs 0, all registers 0, FSM in S_IDLE, synchronisers loaded with 1, which is the bus-idle level.
- Input path: 2-flop synchroniser plus 1 history flop per line. Every event is detected 3 i_clk cycles after the pin change.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are valid in any state.
- START in any state, including a repeated START, clears the bit counter and goes to S_DEV with o_busy=1.
- STOP in any state goes to S_IDLE with o_busy=0 and o_sda_oe=0. A partially received write is discarded.
- Bits are shifted MSB first on each detected SCL rising edge.
- States: S_IDLE(0), S_DEV(1), S_ACK(2), S_B1(3), S_B2(4), S_IGNORE(5).
- S_DEV: after 8 bits, compare byte[7:1] with DEV_ADDR and byte[0] with 0.
  - Match: on the next SCL falling edge set o_sda_oe=1 and enter S_ACK with next=S_B1.
  - Mismatch or read request: leave o_sda_oe=0 and go to S_IGNORE.
- S_ACK: hold o_sda_oe=1 through the ack clock. On the following SCL falling edge set o_sda_oe=0 and go to next.
- S_B1: after 8 bits, latch addr=byte[7:1] and d8=byte[0], ACK, next=S_B2.
- S_B2: after 8 bits, data={d8,byte}. On the SCL falling edge that starts the ACK:
  - pulse o_reg_wr for exactly 1 cycle;
  - update o_reg_addr and o_reg_data;
  - increment o_wr_cnt;
  - write the register file. Addr==RESET_REG clears all registers. Addr>=NUM_REGS does not store, but the write still counts and ACKs.
  - After the ACK go to S_IGNORE.
- S_IGNORE: never drives SDA. Any further data bytes are NACKed (no auto-increment). It waits for STOP or START.
- An SDA change while SCL is high is never treated as data. A simultaneous SCL and SDA edge in one sample is treated as data: SCL is considered first and no START/STOP is detected.
- o_sda_oe never changes while the synchronised SCL is high.
- Reset asserted mid-transfer releases SDA immediately (asynchronously).

Test Plan:
1. Write 0x34, 0x08, 0x15 then STOP -> three ACKs; one o_reg_wr pulse; o_reg_addr=4, o_reg_data=0x015; reading i_rd_addr=4 gives 0x015; o_wr_cnt=1.
2. Write 0x34, 0x0F, 0xFF -> reg7=0x1FF. Then write 0x34, 0x1E, 0x00 -> all registers read 0; o_wr_cnt=2.
3. Wrong address byte 0x36, or read byte 0x35 -> o_sda_oe stays 0 for the whole frame; no o_reg_wr; FSM returns to S_IDLE on STOP.
4. Write 0x34, 0x08 then repeated START and 0x34, 0x0A, 0x01 -> only reg5=0x001 is written; reg4 is unchanged; exactly one pulse.
5. STOP after 4 bits of byte 2 -> no write; o_busy=0 and o_state=0 within 3 cycles.
6. Ten back-to-back writes at SCL = i_clk/8 to addresses 0..9 -> every register matches. Also check SDA is never driven while SCL is high, and a fourth data byte is NACKed.
